// File: rtl/fetch_pkg.sv
// Shared constants, the buffered fetch entry type and a counter-width helper for the
// instruction-fetch slice.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
    } fetch_entry_t;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int unsigned cntWidth(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from the storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = cntWidth(Depth)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [Width-1:0] pushData,
    input  logic             pop,
    input  logic             clear,
    output logic [Width-1:0] headData,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wrPtrQ;
    logic [PtrW-1:0]  rdPtrQ;
    logic [CntW-1:0]  countQ;
    logic             doPush;
    logic             doPop;

    assign empty = (countQ == '0);
    assign full  = (countQ == DepthCnt);

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
        return (ptr == LastIdx) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else if (clear) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) begin
                wrPtrQ <= nextPtr(wrPtrQ);
            end
            if (doPop) begin
                rdPtrQ <= nextPtr(rdPtrQ);
            end
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear) begin
            mem[wrPtrQ] <= pushData;
        end
    end

    assign headData = mem[rdPtrQ];
    assign count    = countQ;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks in-flight imem requests, buffers returned
// instructions for IF/ID and drops responses made stale by a redirect.
module fetch_unit #(
    parameter int unsigned    XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int unsigned    MAX_OUTSTANDING = 2,
    parameter int unsigned    FIFO_DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            pcEnable,
    input  logic            ifidEnable,
    input  logic            ifidClear,
    input  logic            takeBranch_MEM,
    input  logic [XLEN-1:0] branchTarget_MEM,
    output logic            imemReqValid,
    input  logic            imemReqReady,
    output logic [XLEN-1:0] imemReqAddress,
    input  logic            imemRespValid,
    input  logic [31:0]     imemRespData,
    output logic            valid_IF,
    output logic [31:0]     instruction_IF,
    output logic [XLEN-1:0] pc_IF
);

    import fetch_pkg::*;

    localparam int unsigned OutW = cntWidth(MAX_OUTSTANDING);
    localparam int unsigned BufW = cntWidth(FIFO_DEPTH);
    localparam logic [BufW:0] DepthLimit = (BufW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pcQ;
    logic [OutW-1:0] dropCountQ;
    logic [OutW-1:0] outstanding;
    logic [BufW-1:0] bufCount;
    logic [BufW:0]   creditUsed;
    logic [XLEN-1:0] pcqHead;
    fetch_entry_t    bufIn;
    fetch_entry_t    bufHead;
    logic            redirect;
    logic            accept;
    logic            respDrop;
    logic            bufPush;
    logic            bufPop;
    logic            bufEmpty;
    logic            bufFull;
    logic            pcqFull;
    logic            pcqEmpty;
    logic            unusedFlags;

    assign redirect = takeBranch_MEM || ifidClear;
    assign bufPop   = !bufEmpty && ifidEnable && !redirect;
    assign respDrop = imemRespValid && (redirect || (dropCountQ != '0));
    assign bufPush  = imemRespValid && !respDrop;

    // Slots already promised to the buffer; the entry leaving this cycle frees its slot
    // immediately so a ready memory can sustain one instruction per cycle.
    always_comb begin
        creditUsed = (BufW + 1)'(outstanding) + (BufW + 1)'(bufCount) - (BufW + 1)'(bufPop);
    end

    assign imemReqValid   = rstN && pcEnable && !redirect && !pcqFull && (creditUsed < DepthLimit);
    assign accept         = imemReqValid && imemReqReady;
    assign imemReqAddress = pcQ;

    // The PC queue occupancy is exactly the number of accepted-but-unreturned requests.
    fetch_fifo #(
        .Width (XLEN),
        .Depth (MAX_OUTSTANDING)
    ) pcQueue (
        .clk      (clk),
        .rstN     (rstN),
        .push     (accept),
        .pushData (pcQ),
        .pop      (imemRespValid),
        .clear    (1'b0),
        .headData (pcqHead),
        .count    (outstanding),
        .full     (pcqFull),
        .empty    (pcqEmpty)
    );

    always_comb begin
        bufIn.pc          = pcqHead;
        bufIn.instruction = imemRespData;
    end

    fetch_fifo #(
        .Width ($bits(fetch_entry_t)),
        .Depth (FIFO_DEPTH)
    ) instrBuffer (
        .clk      (clk),
        .rstN     (rstN),
        .push     (bufPush),
        .pushData (bufIn),
        .pop      (bufPop),
        .clear    (redirect),
        .headData (bufHead),
        .count    (bufCount),
        .full     (bufFull),
        .empty    (bufEmpty)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pcQ        <= {RESET_PC[XLEN-1:2], 2'b00};
            dropCountQ <= '0;
        end else if (redirect) begin
            pcQ        <= {branchTarget_MEM[XLEN-1:2], 2'b00};
            // Everything still in flight belongs to the old path, including this cycle's reply.
            dropCountQ <= outstanding - OutW'(imemRespValid);
        end else begin
            if (accept) begin
                pcQ <= pcQ + XLEN'(4);
            end
            if (imemRespValid && (dropCountQ != '0)) begin
                dropCountQ <= dropCountQ - 1'b1;
            end
        end
    end

    assign valid_IF       = !bufEmpty;
    assign instruction_IF = bufEmpty ? NOP_INSTR : bufHead.instruction;
    assign pc_IF          = bufEmpty ? '0 : bufHead.pc;

    assign unusedFlags = ^{pcqEmpty, bufFull};

endmodule
